// File: rtl/axis_dest_crossbar.sv
// TDEST-routed AXI-Stream crossbar: packet-atomic round-robin per sink, one register slot per sink.
// Accept-to-M_* latency is one cycle; S_TREADY follows the grant and the slot's free/draining state.
module axis_dest_crossbar #(
  parameter int NUM_IN    = 3,
  parameter int NUM_OUT   = 3,
  parameter int NUM_INW   = 2,
  parameter int DATAW     = 32,
  parameter int IDW       = 32,
  parameter int USERW     = 32,
  parameter int DESTW     = 6,
  parameter int DEST_BASE = 1,
  parameter int DROPW     = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_IN-1:0]        S_TVALID,
  output logic [NUM_IN-1:0]        S_TREADY,
  input  logic [NUM_IN*DATAW-1:0]  S_TDATA,
  input  logic [NUM_IN-1:0]        S_TLAST,
  input  logic [NUM_IN*IDW-1:0]    S_TID,
  input  logic [NUM_IN*USERW-1:0]  S_TUSER,
  input  logic [NUM_IN*DESTW-1:0]  S_TDEST,
  output logic [NUM_OUT-1:0]       M_TVALID,
  input  logic [NUM_OUT-1:0]       M_TREADY,
  output logic [NUM_OUT*DATAW-1:0] M_TDATA,
  output logic [NUM_OUT-1:0]       M_TLAST,
  output logic [NUM_OUT*IDW-1:0]   M_TID,
  output logic [NUM_OUT*USERW-1:0] M_TUSER,
  output logic [NUM_OUT*DESTW-1:0] M_TDEST,
  output logic                     DROP_ERR,
  output logic [DROPW-1:0]         DROP_CNT
);

  localparam int OUTW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUTED, ST_DROP} in_st_t;

  in_st_t               st_q    [NUM_IN];
  in_st_t               st_d    [NUM_IN];
  logic [OUTW-1:0]      route_q [NUM_IN];
  logic [OUTW-1:0]      route_d [NUM_IN];
  logic [NUM_OUT-1:0]   own_q, own_d;
  logic [NUM_INW-1:0]   owner_q [NUM_OUT];
  logic [NUM_INW-1:0]   owner_d [NUM_OUT];
  logic [NUM_INW-1:0]   last_q  [NUM_OUT];
  logic [NUM_INW-1:0]   last_d  [NUM_OUT];

  logic [NUM_OUT-1:0]       m_vld_q, m_vld_d;
  logic [NUM_OUT*DATAW-1:0] m_dat_q, m_dat_d;
  logic [NUM_OUT-1:0]       m_lst_q, m_lst_d;
  logic [NUM_OUT*IDW-1:0]   m_id_q, m_id_d;
  logic [NUM_OUT*USERW-1:0] m_usr_q, m_usr_d;
  logic [NUM_OUT*DESTW-1:0] m_dst_q, m_dst_d;
  logic [DROPW-1:0]         drop_cnt_q, drop_cnt_d;
  logic                     drop_err_q, drop_err_d;

  logic [NUM_IN-1:0]  in_map, in_drop, s_rdy;
  logic [OUTW-1:0]    in_tgt  [NUM_IN];
  logic [NUM_IN-1:0]  req     [NUM_OUT];
  logic [NUM_IN-1:0]  gnt     [NUM_OUT];
  logic [NUM_INW-1:0] gnt_idx [NUM_OUT];
  logic [NUM_OUT-1:0] gnt_any, stage_rdy, acc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_IN; i++) begin
        st_q[i]    <= ST_IDLE;
        route_q[i] <= '0;
      end
      for (int k = 0; k < NUM_OUT; k++) begin
        owner_q[k] <= '0;
        last_q[k]  <= NUM_INW'(NUM_IN - 1);
      end
      own_q      <= '0;
      m_vld_q    <= '0;
      m_dat_q    <= '0;
      m_lst_q    <= '0;
      m_id_q     <= '0;
      m_usr_q    <= '0;
      m_dst_q    <= '0;
      drop_cnt_q <= '0;
      drop_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        st_q[i]    <= st_d[i];
        route_q[i] <= route_d[i];
      end
      for (int k = 0; k < NUM_OUT; k++) begin
        owner_q[k] <= owner_d[k];
        last_q[k]  <= last_d[k];
      end
      own_q      <= own_d;
      m_vld_q    <= m_vld_d;
      m_dat_q    <= m_dat_d;
      m_lst_q    <= m_lst_d;
      m_id_q     <= m_id_d;
      m_usr_q    <= m_usr_d;
      m_dst_q    <= m_dst_d;
      drop_cnt_q <= drop_cnt_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Route decode, per-sink arbitration and source ready.
  always_comb begin
    int d;
    int idx;
    for (int i = 0; i < NUM_IN; i++) begin
      in_map[i]  = 1'b0;
      in_drop[i] = 1'b0;
      in_tgt[i]  = '0;
      d = int'(S_TDEST[i*DESTW +: DESTW]) - DEST_BASE;
      case (st_q[i])
        ST_IDLE: begin
          if (d >= 0 && d < NUM_OUT) begin
            in_map[i] = 1'b1;
            in_tgt[i] = OUTW'(d);
          end else begin
            in_drop[i] = 1'b1;
          end
        end
        ST_ROUTED: begin
          in_map[i] = 1'b1;
          in_tgt[i] = route_q[i];
        end
        default: in_drop[i] = 1'b1;
      endcase
    end

    for (int k = 0; k < NUM_OUT; k++) begin
      stage_rdy[k] = !m_vld_q[k] || M_TREADY[k];
      req[k] = '0;
      for (int i = 0; i < NUM_IN; i++)
        req[k][i] = S_TVALID[i] && in_map[i] && (in_tgt[i] == OUTW'(k));
      gnt_any[k] = 1'b0;
      gnt_idx[k] = '0;
      if (own_q[k]) begin
        if (req[k][owner_q[k]]) begin
          gnt_any[k] = 1'b1;
          gnt_idx[k] = owner_q[k];
        end
      end else begin
        for (int j = 1; j <= NUM_IN; j++) begin
          idx = (int'(last_q[k]) + j) % NUM_IN;
          if (!gnt_any[k] && req[k][idx]) begin
            gnt_any[k] = 1'b1;
            gnt_idx[k] = NUM_INW'(idx);
          end
        end
      end
      acc[k] = gnt_any[k] && stage_rdy[k];
      gnt[k] = '0;
      if (acc[k])
        gnt[k][gnt_idx[k]] = 1'b1;
    end

    for (int i = 0; i < NUM_IN; i++) begin
      s_rdy[i] = in_drop[i];
      for (int k = 0; k < NUM_OUT; k++)
        s_rdy[i] = s_rdy[i] | gnt[k][i];
    end
  end

  always_comb begin
    int sel;
    sel = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      st_d[i]    = st_q[i];
      route_d[i] = route_q[i];
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      owner_d[k] = owner_q[k];
      last_d[k]  = last_q[k];
    end
    own_d      = own_q;
    m_vld_d    = m_vld_q;
    m_dat_d    = m_dat_q;
    m_lst_d    = m_lst_q;
    m_id_d     = m_id_q;
    m_usr_d    = m_usr_q;
    m_dst_d    = m_dst_q;
    drop_cnt_d = drop_cnt_q;
    drop_err_d = drop_err_q;

    for (int i = 0; i < NUM_IN; i++) begin
      if (S_TVALID[i] && s_rdy[i]) begin
        case (st_q[i])
          ST_IDLE: begin
            if (!S_TLAST[i]) begin
              st_d[i]    = in_drop[i] ? ST_DROP : ST_ROUTED;
              route_d[i] = in_tgt[i];
            end
          end
          default: if (S_TLAST[i]) st_d[i] = ST_IDLE;
        endcase
        // Several sources may finish a dropped packet in the same cycle.
        if (S_TLAST[i] && in_drop[i]) begin
          drop_err_d = 1'b1;
          if (drop_cnt_d != '1)
            drop_cnt_d = drop_cnt_d + DROPW'(1);
        end
      end
    end

    for (int k = 0; k < NUM_OUT; k++) begin
      if (acc[k]) begin
        sel        = int'(gnt_idx[k]);
        last_d[k]  = gnt_idx[k];
        owner_d[k] = gnt_idx[k];
        own_d[k]   = !S_TLAST[sel];
        m_vld_d[k] = 1'b1;
        m_dat_d[k*DATAW +: DATAW] = S_TDATA[sel*DATAW +: DATAW];
        m_lst_d[k]                = S_TLAST[sel];
        m_id_d[k*IDW +: IDW]      = S_TID[sel*IDW +: IDW];
        m_usr_d[k*USERW +: USERW] = S_TUSER[sel*USERW +: USERW];
        m_dst_d[k*DESTW +: DESTW] = S_TDEST[sel*DESTW +: DESTW];
      end else if (M_TREADY[k]) begin
        m_vld_d[k] = 1'b0;
      end
    end
  end

  assign S_TREADY = RST ? '0 : s_rdy;
  assign M_TVALID = m_vld_q;
  assign M_TDATA  = m_dat_q;
  assign M_TLAST  = m_lst_q;
  assign M_TID    = m_id_q;
  assign M_TUSER  = m_usr_q;
  assign M_TDEST  = m_dst_q;
  assign DROP_CNT = drop_cnt_q;
  assign DROP_ERR = drop_err_q;

endmodule
